// File: rtl/aes_pkg.sv
// Shared AES constants and the MixColumns engine state encoding.
package aes_pkg;

    localparam int TEXT_WIDTH   = 128;
    localparam int BYTE_WIDTH   = 8;
    localparam int MATRIX_SIZE  = 16;
    localparam int COLUMN_WIDTH = 32;

    // GF(2^8) reduction constant for x^8 + x^4 + x^3 + x + 1
    localparam logic [BYTE_WIDTH-1:0] AES_POLY = 8'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

endpackage

// File: rtl/mix_single_column.sv
// Combinational forward MixColumns on one 32-bit column [a0 a1 a2 a3], a0 in the top byte.
module mix_single_column
    import aes_pkg::*;
(
    input  logic [COLUMN_WIDTH-1:0] col_i,
    output logic [COLUMN_WIDTH-1:0] col_o
);

    function automatic logic [BYTE_WIDTH-1:0] xtime(input logic [BYTE_WIDTH-1:0] x);
        return {x[BYTE_WIDTH-2:0], 1'b0} ^ (x[BYTE_WIDTH-1] ? AES_POLY : 8'h00);
    endfunction

    logic [BYTE_WIDTH-1:0] a0, a1, a2, a3;
    logic [BYTE_WIDTH-1:0] b0, b1, b2, b3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Fixed matrix multiply: 2/3 coefficients expressed through xtime (3x = xtime(x) ^ x)
    always_comb begin
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
    end

    assign col_o = {b0, b1, b2, b3};

endmodule

// File: rtl/mixcolumns_seq.sv
// Column-serial forward AES MixColumns engine with valid/ready input and a held,
// registered result. COLS_PER_CYCLE (1, 2 or 4) columns are mixed per clock.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// The producer holds valid_i/state_i until accepted; the result (valid_o/state_o)
// is held stable until ready_i. state_o carries partial columns while busy, so it
// is only meaningful when valid_o = 1.
module mixcolumns_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] state_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] state_o
);

    mc_state_e               state_q, state_d;
    logic [1:0]              col_q, col_d;
    logic [TEXT_WIDTH-1:0]   buf_q, buf_d;
    logic [TEXT_WIDTH-1:0]   state_o_q, state_o_d;
    logic                    valid_o_q, valid_o_d;

    logic [1:0]              col_idx [COLS_PER_CYCLE];
    logic [COLUMN_WIDTH-1:0] col_in  [COLS_PER_CYCLE];
    logic [COLUMN_WIDTH-1:0] col_out [COLS_PER_CYCLE];
    logic                    accept;
    logic                    last_group;

    // Ready in IDLE, or in DONE once the current result is being taken (back-to-back)
    assign ready_o    = (state_q == IDLE) || ((state_q == DONE) && ready_i);
    assign accept     = valid_i && ready_o;
    assign last_group = (col_q + 2'(COLS_PER_CYCLE - 1)) == 2'd3;

    // One mixer per column slot; the counter selects which buffered columns they see
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign col_idx[k] = col_q + 2'(k);
        assign col_in[k]  = buf_q[TEXT_WIDTH-1-COLUMN_WIDTH*int'(col_idx[k]) -: COLUMN_WIDTH];
        mix_single_column u_mix (
            .col_i (col_in[k]),
            .col_o (col_out[k])
        );
    end

    // Next-state logic: capture, column sweep, and result hold/release
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        buf_d     = buf_q;
        state_o_d = state_o_q;
        valid_o_d = valid_o_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    buf_d   = state_i;
                    col_d   = 2'd0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    state_o_d[TEXT_WIDTH-1-COLUMN_WIDTH*int'(col_idx[k]) -: COLUMN_WIDTH] = col_out[k];
                end
                col_d = col_q + 2'(COLS_PER_CYCLE);
                if (last_group) begin
                    state_d   = DONE;
                    valid_o_d = 1'b1;
                end
            end
            DONE: begin
                if (ready_i) begin
                    valid_o_d = 1'b0;
                    if (valid_i) begin
                        buf_d   = state_i;
                        col_d   = 2'd0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                valid_o_d = 1'b0;
            end
        endcase
    end

    // State registers; reset aborts any block in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            col_q     <= 2'd0;
            buf_q     <= '0;
            state_o_q <= '0;
            valid_o_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            buf_q     <= buf_d;
            state_o_q <= state_o_d;
            valid_o_q <= valid_o_d;
        end
    end

    assign valid_o = valid_o_q;
    assign state_o = state_o_q;

endmodule
